// File: rtl/fp_add_pkg.sv
// Shared definitions for the FP adder normalization stage: FSM states,
// exponent limit and bit offsets of the aligned-sum word.
package fp_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } norm_state_e;

    localparam logic [7:0] EXP_MAX = 8'd255;

    // sum word layout, LSB first: S, R, G, frac[MAN_W-1:0], hidden, carry
    localparam int SUM_S_POS    = 0;
    localparam int SUM_R_POS    = 1;
    localparam int SUM_G_POS    = 2;
    localparam int SUM_FRAC_LSB = 3;
    localparam int SUM_HID_OFS  = 3;  // hidden bit = MAN_W + SUM_HID_OFS
    localparam int SUM_CRY_OFS  = 4;  // carry bit  = MAN_W + SUM_CRY_OFS

endpackage

// File: rtl/fadd_normalize_fp_if.sv
// Upstream/downstream handshake bundle of the normalization stage.
interface fadd_normalize_fp_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic               in_valid;
    logic               in_ready;
    logic               sign_in;
    logic [EXP_W-1:0]   exp_in;
    logic [MAN_W+4:0]   sum_in;
    logic [7:0]         flags_in;

    logic               out_valid;
    logic               out_ready;
    logic               sign_res;
    logic [EXP_W-1:0]   exp_norm;
    logic [MAN_W-1:0]   mantissa_norm;
    logic [2:0]         grs;
    logic               underflow;
    logic [7:0]         flags_out;

    modport master (
        output in_valid, sign_in, exp_in, sum_in, flags_in, out_ready,
        input  in_ready, out_valid, sign_res, exp_norm, mantissa_norm, grs,
               underflow, flags_out
    );

    modport slave (
        input  in_valid, sign_in, exp_in, sum_in, flags_in, out_ready,
        output in_ready, out_valid, sign_res, exp_norm, mantissa_norm, grs,
               underflow, flags_out
    );
endinterface

// File: rtl/fadd_normalize_fp.sv
// Post-alignment normalization: one right shift on carry, iterative left
// shifts for cancellation, underflow clamp; one op in flight, registered outputs.
module fadd_normalize_fp
    import fp_add_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    fadd_normalize_fp_if.slave bus
);
    localparam int SUM_W = MAN_W + 5;
    localparam int CRY   = MAN_W + SUM_CRY_OFS;
    localparam int HID   = MAN_W + SUM_HID_OFS;

    norm_state_e        state_q;
    logic               sign_q;
    logic               unf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [EXP_W-1:0]   exp_q;
    logic [SUM_W-1:0]   sum_q;
    logic [7:0]         flags_q;

    logic [SUM_W-1:0]   sum_rsh_d;
    logic [SUM_W-1:0]   sum_lsh_d;

    // Carry: old hidden drops into the fraction, sticky absorbs R and S.
    assign sum_rsh_d = {2'b01, sum_q[HID:SUM_FRAC_LSB], sum_q[SUM_G_POS],
                        sum_q[SUM_R_POS] | sum_q[SUM_S_POS]};
    assign sum_lsh_d = {1'b0, sum_q[HID-1:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            unf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            exp_q       <= '0;
            sum_q       <= '0;
            flags_q     <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q     <= bus.sign_in;
                        exp_q      <= bus.exp_in;
                        sum_q      <= bus.sum_in;
                        flags_q    <= bus.flags_in;
                        unf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= EVAL;
                    end
                end
                EVAL: begin
                    if (sum_q == '0) begin
                        exp_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (sum_q[CRY]) begin
                        // exponent may wrap to all-ones; overflow is judged downstream
                        sum_q       <= sum_rsh_d;
                        exp_q       <= exp_q + 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (sum_q[HID]) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (exp_q == '0) begin
                        unf_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (exp_q == EXP_W'(1)) begin
                        unf_q       <= 1'b1;
                        exp_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        sum_q <= sum_lsh_d;
                        exp_q <= exp_q - 1'b1;
                        if (sum_q[HID-1]) begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.sign_res      = sign_q;
    assign bus.exp_norm      = exp_q;
    assign bus.mantissa_norm = sum_q[HID-1:SUM_FRAC_LSB];
    assign bus.grs           = sum_q[SUM_G_POS:SUM_S_POS];
    assign bus.underflow     = unf_q;
    assign bus.flags_out     = flags_q;

endmodule

// File: tb/tb_fadd_normalize_fp.sv
// Directed bench for the normalization stage: carry, shift, underflow, zero,
// backpressure, reset and flush abort, with hand-computed expectations.
module tb_fadd_normalize_fp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   lat;
    bit   seen;

    always #5 clk = ~clk;

    fadd_normalize_fp_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fadd_normalize_fp #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one op at a negedge, accept on the next posedge, then count
    // posedges (accept edge included) until out_valid is seen.
    task automatic send(input logic s, input logic [7:0] e, input logic c, input logic h,
                        input logic [22:0] f, input logic [2:0] g, input logic [7:0] fl);
        @(negedge clk);
        chk("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.sign_in  = s;
        bus.exp_in   = e;
        bus.sum_in   = {c, h, f, g};
        bus.flags_in = fl;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic result(input string tag, input logic [7:0] e, input logic [22:0] m,
                          input logic [2:0] g, input logic u, input logic s,
                          input logic [7:0] fl, input int l);
        chk({tag, "_lat"},   lat, l);
        chk({tag, "_ov"},    {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_exp"},   {24'd0, bus.exp_norm}, {24'd0, e});
        chk({tag, "_man"},   {9'd0, bus.mantissa_norm}, {9'd0, m});
        chk({tag, "_grs"},   {29'd0, bus.grs}, {29'd0, g});
        chk({tag, "_unf"},   {31'd0, bus.underflow}, {31'd0, u});
        chk({tag, "_sign"},  {31'd0, bus.sign_res}, {31'd0, s});
        chk({tag, "_flags"}, {24'd0, bus.flags_out}, {24'd0, fl});
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_xfer_ov"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_xfer_ir"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = '0;
        bus.sum_in    = '0;
        bus.flags_in  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ov",    {31'd0, bus.out_valid}, 32'd0);
        chk("rst_ir",    {31'd0, bus.in_ready}, 32'd1);
        chk("rst_exp",   {24'd0, bus.exp_norm}, 32'd0);
        chk("rst_man",   {9'd0, bus.mantissa_norm}, 32'd0);
        chk("rst_grs",   {29'd0, bus.grs}, 32'd0);
        chk("rst_unf",   {31'd0, bus.underflow}, 32'd0);
        chk("rst_flags", {24'd0, bus.flags_out}, 32'd0);

        // carry: right shift, exp+1
        send(1'b0, 8'd127, 1'b1, 1'b1, 23'h000001, 3'b100, 8'h15);
        result("carry", 8'd128, 23'h400000, 3'b110, 1'b0, 1'b0, 8'h15, 2);
        take("carry");

        // two left shifts
        send(1'b1, 8'd127, 1'b0, 1'b0, 23'h200000, 3'b000, 8'h01);
        result("shift", 8'd125, 23'h000000, 3'b000, 1'b0, 1'b1, 8'h01, 4);
        take("shift");

        // underflow after two shifts
        send(1'b0, 8'd3, 1'b0, 1'b0, 23'h000100, 3'b000, 8'h00);
        result("unf", 8'd0, 23'h000400, 3'b000, 1'b1, 1'b0, 8'h00, 5);
        take("unf");

        // zero sum
        send(1'b1, 8'd100, 1'b0, 1'b0, 23'h000000, 3'b000, 8'hA3);
        result("zero", 8'd0, 23'h000000, 3'b000, 1'b0, 1'b1, 8'hA3, 2);
        take("zero");

        // already normalized
        send(1'b0, 8'd50, 1'b0, 1'b1, 23'h123456, 3'b101, 8'h5C);
        result("norm", 8'd50, 23'h123456, 3'b101, 1'b0, 1'b0, 8'h5C, 2);
        take("norm");

        // carry reaching the exponent limit
        send(1'b0, 8'd254, 1'b1, 1'b0, 23'h000003, 3'b011, 8'h00);
        result("cmax", 8'd255, 23'h000001, 3'b101, 1'b0, 1'b0, 8'h00, 2);
        take("cmax");

        // exponent already zero with subnormal sum
        send(1'b1, 8'd0, 1'b0, 1'b0, 23'h000010, 3'b110, 8'h07);
        result("ezero", 8'd0, 23'h000010, 3'b110, 1'b1, 1'b1, 8'h07, 2);
        take("ezero");

        // backpressure: hold DONE for 5 cycles
        send(1'b0, 8'd127, 1'b0, 1'b0, 23'h200000, 3'b000, 8'h42);
        result("bp", 8'd125, 23'h000000, 3'b000, 1'b0, 1'b0, 8'h42, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_ov",  {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_ir",  {31'd0, bus.in_ready}, 32'd0);
            chk("bp_hold_exp", {24'd0, bus.exp_norm}, 32'd125);
            chk("bp_hold_flg", {24'd0, bus.flags_out}, 32'h42);
        end
        take("bp");

        // async reset in the middle of a long shift sequence
        send(1'b0, 8'd100, 1'b0, 1'b0, 23'h000001, 3'b000, 8'h00);
        chk("long_shift_lat", lat, 25);
        take("long_shift");
        bus.in_valid = 1'b1;
        bus.sign_in  = 1'b1;
        bus.exp_in   = 8'd100;
        bus.sum_in   = {2'b00, 23'h000001, 3'b000};
        bus.flags_in = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_shift_ov", {31'd0, bus.out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_ov",  {31'd0, bus.out_valid}, 32'd0);
        chk("arst_ir",  {31'd0, bus.in_ready}, 32'd1);
        chk("arst_exp", {24'd0, bus.exp_norm}, 32'd0);
        chk("arst_flg", {24'd0, bus.flags_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("arst_no_pulse", {31'd0, seen}, 32'd0);

        // flush while holding a result in DONE
        send(1'b0, 8'd127, 1'b0, 1'b0, 23'h200000, 3'b000, 8'h11);
        chk("fl_pre_ov", {31'd0, bus.out_valid}, 32'd1);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_ov", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_ir", {31'd0, bus.in_ready}, 32'd1);

        send(1'b1, 8'd127, 1'b1, 1'b1, 23'h000001, 3'b100, 8'h3C);
        result("post", 8'd128, 23'h400000, 3'b110, 1'b0, 1'b1, 8'h3C, 2);
        take("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
